// File: rtl/alu_bist_driver.sv
// alu_bist_driver: built-in self-test initiator for the 32-bit ALU.
// Two LFSRs drive operands A/B, a wrapping counter drives ALUOp, and the
// ALU response (C, eq) is folded into a 32-bit MISR signature that is
// compared against GOLDEN_SIG when the run completes.
// Optional feature: define ALU_BIST_HOLD_EN to add a 'hold' input that
// freezes the RUN state (no vector advance, no signature update).
module alu_bist_driver #(
  parameter int          NUM_VEC    = 16,
  parameter int          OP_MAX     = 7,
  parameter logic [31:0] SEED_A     = 32'h0000_0001,
  parameter logic [31:0] SEED_B     = 32'h8000_0000,
  parameter logic [31:0] POLY       = 32'h04C1_1DB7,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef ALU_BIST_HOLD_EN
  input  logic        hold,
`endif
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALUOp,
  input  logic [31:0] C,
  input  logic        eq,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  // Counter only needs to reach NUM_VEC-1; keep at least one bit for NUM_VEC=1.
  localparam int CNT_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VEC - 1);
  localparam logic [2:0]       OP_LAST  = 3'(OP_MAX);

  // An all-zero LFSR state would lock up, so zero seeds become 1.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              hold_w;
  logic              advance;
  logic              last_vec;
  logic [31:0]       sig_step;

  // Shared Galois step used by both operand LFSRs and the MISR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
  endfunction

`ifdef ALU_BIST_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // A RUN cycle advances only when not held; hold has no effect elsewhere.
  assign advance  = (state_q == S_RUN) && !hold_w;
  assign last_vec = (cnt_q == CNT_LAST);
  assign sig_step = lfsr_step(sig_q) ^ C ^ {31'b0, eq};

  // State and datapath registers; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= 3'd0;
      sig_q   <= 32'h0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (advance && last_vec) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: seed in LOAD, step every advancing RUN cycle.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Accepting a new run drops the previous verdict immediately.
        if (start) begin
          pass_d = 1'b0;
          sig_d  = 32'h0;
        end
      end
      S_LOAD: begin
        a_d    = SEED_A_EFF;
        b_d    = SEED_B_EFF;
        op_d   = 3'd0;
        cnt_d  = '0;
        sig_d  = 32'h0;
        pass_d = 1'b0;
      end
      S_RUN: begin
        if (advance) begin
          sig_d = sig_step;
          a_d   = lfsr_step(a_q);
          b_d   = lfsr_step(b_q);
          op_d  = (op_q == OP_LAST) ? 3'd0 : op_q + 3'd1;
          cnt_d = cnt_q + CNT_W'(1);
          // Verdict is registered together with the final signature.
          if (last_vec) pass_d = (sig_step == GOLDEN_SIG);
        end
      end
      default: ;
    endcase
  end

  // Output decode from the registered state and datapath.
  always_comb begin
    busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    A         = a_q;
    B         = b_q;
    ALUOp     = op_q;
    signature = sig_q;
  end

endmodule
